// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types, opcodes and IR field layout for the ALU control sequencer
//
// Contents:
//   state_t        : sequencer state encoding (IDLE, T0..T6)
//   OP_*           : supported opcode values
//   *_MSB          : IR field MSB positions for the default 32-bit layout
//   field_msb()    : MSB of register field 'slot' (0=ra, 1=rb, 2=rc) for any layout

package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_T6   = 3'd7
    } state_t;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01010;
    localparam logic [4:0] OP_OR  = 5'b01011;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    // Default layout: opcode[31:27], ra[26:23], rb[22:19], rc[18:15].
    localparam int OPC_MSB = 31;
    localparam int RA_MSB  = 26;
    localparam int RB_MSB  = 22;
    localparam int RC_MSB  = 18;

    // Register fields are packed MSB-first directly below the opcode.
    function automatic int field_msb(int irw, int opw, int idx_w, int slot);
        return irw - opw - 1 - slot * idx_w;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_reg_onehot_dec.sv
// rtl/alu_seq_ctrl_reg_onehot_dec.sv - register index to one-hot enable decoder
//
// Module reg_onehot_dec
//   idx    : in  REG_IDX_W  register index
//   en     : in  1          decoder enable; 0 gives all-zero
//   onehot : out NUM_REGS   one-hot select; all-zero when idx >= NUM_REGS

module reg_onehot_dec #(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4
) (
    input  logic [REG_IDX_W-1:0] idx,
    input  logic                 en,
    output logic [NUM_REGS-1:0]  onehot
);

    // Only indices below NUM_REGS have an output bit, so an out-of-range
    // index matches nothing and the result is all-zero.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (idx == REG_IDX_W'(i));
        end
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - hardwired fetch/execute control sequencer for a three-operand register ALU
//
// Optional feature macro: ALU_SEQ_HILO_EN (adds MUL/DIV with two-word LO/HI write-back)
//
// Ports:
//   clk, clr           : clock, synchronous active-low reset
//   start              : begin an instruction cycle (sampled in IDLE only)
//   mem_rdy            : memory read data valid (releases T1)
//   ir                 : IR register contents
//   Rin, Rout          : one-hot register load / drive enables
//   PCout..LOin        : datapath strobes
//   alu_op             : ALU opcode, valid in T4, else 0
//   busy               : high in every non-IDLE state
//   done               : pulse in the final execute state
//   illegal            : pulse in T3 on an unsupported opcode or register index

module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4,
    parameter int OPW       = 5,
    parameter int IRW       = 32
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic                 mem_rdy,
    input  logic [IRW-1:0]       ir,
    output logic [NUM_REGS-1:0]  Rin,
    output logic [NUM_REGS-1:0]  Rout,
    output logic                 PCout,
    output logic                 PCin,
    output logic                 incPC,
    output logic                 MARin,
    output logic                 Read,
    output logic                 MDRin,
    output logic                 MDRout,
    output logic                 IRin,
    output logic                 Yin,
    output logic                 Zin,
    output logic                 ZLowOut,
    output logic                 ZHighOut,
    output logic                 HIin,
    output logic                 LOin,
    output logic [OPW-1:0]       alu_op,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal
);

    localparam int F_RA_MSB = field_msb(IRW, OPW, REG_IDX_W, 0);
    localparam int F_RB_MSB = field_msb(IRW, OPW, REG_IDX_W, 1);
    localparam int F_RC_MSB = field_msb(IRW, OPW, REG_IDX_W, 2);
    localparam int LOW_W    = IRW - OPW - 3 * REG_IDX_W;
    localparam logic [REG_IDX_W:0] REG_LIMIT = (REG_IDX_W + 1)'(NUM_REGS);

    state_t               state;
    state_t               state_nxt;
    logic [OPW-1:0]       op_q;
    logic [REG_IDX_W-1:0] ra_q;
    logic [REG_IDX_W-1:0] rb_q;
    logic [REG_IDX_W-1:0] rc_q;

    logic                 op_ok;
    logic                 hilo_op;
    logic                 regs_ok;
    logic                 legal;

    logic                 rin_en;
    logic                 rout_en;
    logic [REG_IDX_W-1:0] rout_idx;

    // IR bits below rc carry no meaning for register-ALU instructions.
    generate
        if (LOW_W > 0) begin : g_ir_low
            logic unused_ir_low;
            assign unused_ir_low = ^ir[LOW_W-1:0];
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction fields are captured as T3 is entered and held for the
    // rest of the instruction, so T3..T6 see a stable decode.
    always_ff @(posedge clk) begin
        if (!clr) begin
            op_q <= '0;
            ra_q <= '0;
            rb_q <= '0;
            rc_q <= '0;
        end else if (state == ST_T2) begin
            op_q <= ir[IRW-1 -: OPW];
            ra_q <= ir[F_RA_MSB -: REG_IDX_W];
            rb_q <= ir[F_RB_MSB -: REG_IDX_W];
            rc_q <= ir[F_RC_MSB -: REG_IDX_W];
        end
    end

    // Opcode decode from the latched fields only (keeps outputs Moore).
    always_comb begin
        op_ok   = 1'b0;
        hilo_op = 1'b0;
        case (op_q)
            OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_AND), OPW'(OP_OR),
            OPW'(OP_SHR), OPW'(OP_SHL), OPW'(OP_ROR), OPW'(OP_ROL),
            OPW'(OP_NEG), OPW'(OP_NOT): op_ok = 1'b1;
`ifdef ALU_SEQ_HILO_EN
            OPW'(OP_MUL), OPW'(OP_DIV): begin
                op_ok   = 1'b1;
                hilo_op = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign regs_ok = ({1'b0, ra_q} < REG_LIMIT) &&
                     ({1'b0, rb_q} < REG_LIMIT) &&
                     ({1'b0, rc_q} < REG_LIMIT);
    assign legal   = op_ok && regs_ok;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_T0;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   if (mem_rdy) state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3:   state_nxt = legal ? ST_T4 : ST_IDLE;
            ST_T4:   state_nxt = ST_T5;
            ST_T5:   state_nxt = hilo_op ? ST_T6 : ST_IDLE;
            ST_T6:   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        incPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        alu_op   = '0;
        done     = 1'b0;
        illegal  = 1'b0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rout_idx = rb_q;
        busy     = (state != ST_IDLE);
        case (state)
            ST_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                incPC = 1'b1;
                Zin   = 1'b1;
            end
            // Held for every wait cycle; reloading PC from Z is idempotent.
            ST_T1: begin
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                if (legal) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            ST_T4: begin
                rout_en  = 1'b1;
                rout_idx = rc_q;
                Zin      = 1'b1;
                alu_op   = op_q;
            end
            ST_T5: begin
                ZLowOut = 1'b1;
                if (hilo_op) begin
                    LOin = 1'b1;
                end else begin
                    rin_en = 1'b1;
                    done   = 1'b1;
                end
            end
            ST_T6: begin
`ifdef ALU_SEQ_HILO_EN
                ZHighOut = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    reg_onehot_dec #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_rin_dec (
        .idx    (ra_q),
        .en     (rin_en),
        .onehot (Rin)
    );

    reg_onehot_dec #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W)
    ) u_rout_dec (
        .idx    (rout_idx),
        .en     (rout_en),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl

module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic        mem_rdy;
    logic [31:0] ir;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCout, PCin, incPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin;
    logic [4:0]  alu_op;
    logic        busy, done, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .mem_rdy  (mem_rdy),
        .ir       (ir),
        .Rin      (Rin),
        .Rout     (Rout),
        .PCout    (PCout),
        .PCin     (PCin),
        .incPC    (incPC),
        .MARin    (MARin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .ZLowOut  (ZLowOut),
        .ZHighOut (ZHighOut),
        .HIin     (HIin),
        .LOin     (LOin),
        .alu_op   (alu_op),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal)
    );

    // Strobe vector bit positions, MSB first.
    localparam logic [13:0] B_PCOUT  = 14'h2000;
    localparam logic [13:0] B_PCIN   = 14'h1000;
    localparam logic [13:0] B_INCPC  = 14'h0800;
    localparam logic [13:0] B_MARIN  = 14'h0400;
    localparam logic [13:0] B_READ   = 14'h0200;
    localparam logic [13:0] B_MDRIN  = 14'h0100;
    localparam logic [13:0] B_MDROUT = 14'h0080;
    localparam logic [13:0] B_IRIN   = 14'h0040;
    localparam logic [13:0] B_YIN    = 14'h0020;
    localparam logic [13:0] B_ZIN    = 14'h0010;
    localparam logic [13:0] B_ZLO    = 14'h0008;
    localparam logic [13:0] B_ZHI    = 14'h0004;
    localparam logic [13:0] B_HIIN   = 14'h0002;
    localparam logic [13:0] B_LOIN   = 14'h0001;

    localparam logic [13:0] E_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [13:0] E_T1 = B_ZLO | B_PCIN | B_READ | B_MDRIN;
    localparam logic [13:0] E_T2 = B_MDROUT | B_IRIN;

    logic [13:0] strobes;
    assign strobes = {PCout, PCin, incPC, MARin, Read, MDRin, MDRout, IRin,
                      Yin, Zin, ZLowOut, ZHighOut, HIin, LOin};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against one expected cycle.
    task automatic expect_cyc(input string tag, input logic [13:0] s, input logic [15:0] rin,
                              input logic [15:0] rout, input logic [4:0] op,
                              input logic b, input logic d, input logic il);
        check({tag, ".strobes"}, 32'(strobes), 32'(s));
        check({tag, ".Rin"},     32'(Rin),     32'(rin));
        check({tag, ".Rout"},    32'(Rout),    32'(rout));
        check({tag, ".alu_op"},  32'(alu_op),  32'(op));
        check({tag, ".flags"},   32'({busy, done, illegal}), 32'({b, d, il}));
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc, 15'h0};
    endfunction

    // Pulse start, then check T0, T1, T2 with no memory wait.
    task automatic fetch(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_cyc({tag, ".T0"}, E_T0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc({tag, ".T1"}, E_T1, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc({tag, ".T2"}, E_T2, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic expect_idle(input string tag);
        expect_cyc(tag, 14'h0, 16'h0, 16'h0, 5'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        clr     = 1'b0;
        start   = 1'b0;
        mem_rdy = 1'b1;
        ir      = 32'h0;
        tick();
        tick();
        expect_idle("reset");
        clr = 1'b1;
        tick();
        expect_idle("idle_after_reset");

        // OR r1,r2,r3 with no memory wait.
        ir = mk_ir(5'b01011, 4'd1, 4'd2, 4'd3);
        fetch("or");
        tick();
        expect_cyc("or.T3", B_YIN, 16'h0, 16'h0004, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("or.T4", B_ZIN, 16'h0, 16'h0008, 5'b01011, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("or.T5", B_ZLO, 16'h0002, 16'h0, 5'h0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_idle("or.end");

        // Same instruction with three wait cycles in T1.
        mem_rdy = 1'b0;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        expect_cyc("wait.T0", E_T0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_cyc($sformatf("wait.T1_%0d", i), E_T1, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
        end
        mem_rdy = 1'b1;
        tick();
        expect_cyc("wait.T2", E_T2, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("wait.T3", B_YIN, 16'h0, 16'h0004, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("wait.T4", B_ZIN, 16'h0, 16'h0008, 5'b01011, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("wait.T5", B_ZLO, 16'h0002, 16'h0, 5'h0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_idle("wait.end");

        // ADD r0,r15,r7: R0 written normally, top register index.
        ir = mk_ir(5'b00011, 4'd0, 4'd15, 4'd7);
        fetch("add");
        tick();
        expect_cyc("add.T3", B_YIN, 16'h0, 16'h8000, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("add.T4", B_ZIN, 16'h0, 16'h0080, 5'b00011, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("add.T5", B_ZLO, 16'h0001, 16'h0, 5'h0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_idle("add.end");

        // Unsupported opcode 11111.
        ir = mk_ir(5'b11111, 4'd1, 4'd2, 4'd3);
        fetch("ill");
        tick();
        expect_cyc("ill.T3", 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b1);
        tick();
        expect_idle("ill.end");

        // MUL r0,r4,r5.
        ir = mk_ir(5'b01110, 4'd0, 4'd4, 4'd5);
        fetch("mul");
        tick();
`ifdef ALU_SEQ_HILO_EN
        expect_cyc("mul.T3", B_YIN, 16'h0, 16'h0010, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("mul.T4", B_ZIN, 16'h0, 16'h0020, 5'b01110, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("mul.T5", B_ZLO | B_LOIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("mul.T6", B_ZHI | B_HIIN, 16'h0, 16'h0, 5'h0, 1'b1, 1'b1, 1'b0);
`else
        expect_cyc("mul.T3", 14'h0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b1);
`endif
        tick();
        expect_idle("mul.end");

        // Reset asserted while in T4.
        ir = mk_ir(5'b01011, 4'd1, 4'd2, 4'd3);
        fetch("rst");
        tick();
        expect_cyc("rst.T3", B_YIN, 16'h0, 16'h0004, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("rst.T4", B_ZIN, 16'h0, 16'h0008, 5'b01011, 1'b1, 1'b0, 1'b0);
        clr = 1'b0;
        tick();
        expect_idle("rst.after");
        clr = 1'b1;
        tick();
        expect_idle("rst.hold");

        // start pulsed during T2 is ignored and causes no restart.
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_cyc("ign.T0", E_T0, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("ign.T1", E_T1, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("ign.T2", E_T2, 16'h0, 16'h0, 5'h0, 1'b1, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        expect_cyc("ign.T3", B_YIN, 16'h0, 16'h0004, 5'h0, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("ign.T4", B_ZIN, 16'h0, 16'h0008, 5'b01011, 1'b1, 1'b0, 1'b0);
        tick();
        expect_cyc("ign.T5", B_ZLO, 16'h0002, 16'h0, 5'h0, 1'b1, 1'b1, 1'b0);
        tick();
        expect_idle("ign.end");
        tick();
        expect_idle("ign.no_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
